// File: rtl/serial_magnitude_comparator.sv
// Bit-serial unsigned magnitude comparator: operands captured on start, compared
// MSB first, one bit per cycle, with fixed N-cycle latency and a one-cycle done.
module serial_magnitude_comparator #(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic         busy,
   output logic         done,
   output logic         a_greater,
   output logic         a_equal,
   output logic         a_lesser
);

   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [N-1:0]  shift_a_q, shift_a_d;
   logic [N-1:0]  shift_b_q, shift_b_d;
   logic          gt_q, gt_d;
   logic          lt_q, lt_d;
   logic          a_greater_q, a_greater_d;
   logic          a_equal_q, a_equal_d;
   logic          a_lesser_q, a_lesser_d;

   logic          bit_a, bit_b, undecided, gt_nxt, lt_nxt;

   // First differing bit decides; afterwards the decision is frozen.
   assign bit_a     = shift_a_q[N-1];
   assign bit_b     = shift_b_q[N-1];
   assign undecided = !gt_q && !lt_q;
   assign gt_nxt    = gt_q || (undecided && bit_a && !bit_b);
   assign lt_nxt    = lt_q || (undecided && !bit_a && bit_b);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      shift_a_d   = shift_a_q;
      shift_b_d   = shift_b_q;
      gt_d        = gt_q;
      lt_d        = lt_q;
      a_greater_d = a_greater_q;
      a_equal_d   = a_equal_q;
      a_lesser_d  = a_lesser_q;
      case (state_q)
         RUN: begin
            gt_d      = gt_nxt;
            lt_d      = lt_nxt;
            shift_a_d = {shift_a_q[N-2:0], 1'b0};
            shift_b_d = {shift_b_q[N-2:0], 1'b0};
            if (cnt_q == LAST) begin
               state_d     = DONE;
               a_greater_d = gt_nxt;
               a_lesser_d  = lt_nxt;
               a_equal_d   = !(gt_nxt || lt_nxt);
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: begin
            state_d = IDLE;
            if (start) begin
               state_d   = RUN;
               shift_a_d = a;
               shift_b_d = b;
               cnt_d     = '0;
               gt_d      = 1'b0;
               lt_d      = 1'b0;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         shift_a_q   <= '0;
         shift_b_q   <= '0;
         gt_q        <= 1'b0;
         lt_q        <= 1'b0;
         a_greater_q <= 1'b0;
         a_equal_q   <= 1'b0;
         a_lesser_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         shift_a_q   <= shift_a_d;
         shift_b_q   <= shift_b_d;
         gt_q        <= gt_d;
         lt_q        <= lt_d;
         a_greater_q <= a_greater_d;
         a_equal_q   <= a_equal_d;
         a_lesser_q  <= a_lesser_d;
      end
   end

   assign busy      = (state_q == RUN);
   assign done      = (state_q == DONE);
   assign a_greater = a_greater_q;
   assign a_equal   = a_equal_q;
   assign a_lesser  = a_lesser_q;

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Self-checking bench for serial_magnitude_comparator: directed corner cases plus
// randomized compares (with ignored-start noise) checked against integer compares.
module tb_serial_magnitude_comparator;

   localparam int N = 8;

   logic         clk = 1'b0;
   logic         rst, start;
   logic [N-1:0] a, b;
   logic         busy, done, a_greater, a_equal, a_lesser;

   int n_tests = 0;
   int n_fail  = 0;
   logic eg, ee, el;   // reference flags: last completed result

   serial_magnitude_comparator #(.N(N)) dut (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
      .busy(busy), .done(done),
      .a_greater(a_greater), .a_equal(a_equal), .a_lesser(a_lesser)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Accept a compare, walk all N RUN cycles, check the done cycle.
   task automatic do_cmp(input logic [N-1:0] va, input logic [N-1:0] vb, input bit noise);
      start = 1'b1; a = va; b = vb;
      step();
      start = 1'b0;
      for (int i = 0; i < N; i++) begin
         chk("busy_run", busy, 1);
         chk("done_run", done, 0);
         chk("flags_hold", {a_greater, a_equal, a_lesser}, {eg, ee, el});
         if (noise) begin
            a = N'($urandom); b = N'($urandom);
            start = 1'($urandom_range(0, 1));
         end
         step();
      end
      start = 1'b0;
      eg = (va > vb); ee = (va == vb); el = (va < vb);
      chk("busy_done", busy, 0);
      chk("done_pulse", done, 1);
      chk("flags_result", {a_greater, a_equal, a_lesser}, {eg, ee, el});
   endtask

   task automatic idle_chk(input string tag);
      step();
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_flags"}, {a_greater, a_equal, a_lesser}, {eg, ee, el});
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; a = '0; b = '0;
      eg = 1'b0; ee = 1'b0; el = 1'b0;
      step(); step();
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_flags", {a_greater, a_equal, a_lesser}, 0);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) idle_chk("idle");

      // directed extremes and late-deciding bits
      do_cmp(8'hA5, 8'h3C, 1'b0); idle_chk("ret_idle");
      do_cmp(8'h80, 8'h81, 1'b0); idle_chk("ret_idle");
      do_cmp(8'hFF, 8'hFF, 1'b0); idle_chk("ret_idle");
      do_cmp(8'h00, 8'hFF, 1'b0); idle_chk("ret_idle");
      do_cmp(8'hFF, 8'h00, 1'b0); idle_chk("ret_idle");

      // start and operand churn during RUN must be ignored
      do_cmp(8'h10, 8'h20, 1'b1);
      a = '0; b = '0;
      idle_chk("no_second"); idle_chk("no_second");

      // back-to-back: second start lands in the DONE cycle
      do_cmp(8'h3C, 8'hA5, 1'b0);
      do_cmp(8'h7F, 8'h7E, 1'b0);
      idle_chk("b2b_idle");

      // reset during the 4th RUN cycle aborts the compare
      start = 1'b1; a = 8'h01; b = 8'h02;
      step();
      start = 1'b0;
      step(); step(); step();
      chk("pre_abort_busy", busy, 1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      eg = 1'b0; ee = 1'b0; el = 1'b0;
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_flags", {a_greater, a_equal, a_lesser}, 0);
      for (int i = 0; i < N + 2; i++) idle_chk("abort_quiet");
      do_cmp(8'h55, 8'h55, 1'b0); idle_chk("post_abort");

      // reset wins over simultaneous start
      rst = 1'b1; start = 1'b1; a = 8'h09; b = 8'h03;
      step();
      rst = 1'b0; start = 1'b0;
      eg = 1'b0; ee = 1'b0; el = 1'b0;
      chk("rst_start_busy", busy, 0);
      chk("rst_start_flags", {a_greater, a_equal, a_lesser}, 0);
      idle_chk("rst_start_idle");

      // randomized compares, mixed back-to-back and idle gaps
      for (int t = 0; t < 40; t++) begin
         logic [N-1:0] ra, rb;
         ra = N'($urandom);
         rb = ($urandom_range(0, 3) == 0) ? ra : N'($urandom);
         do_cmp(ra, rb, 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 1) == 1) idle_chk("rnd_idle");
      end
      idle_chk("final_idle");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/serial_magnitude_comparator.md
Name: serial_magnitude_comparator

Overview:
Bit-serial counterpart of the team's parallel N-bit magnitude comparator, for area-constrained datapaths. Operands are captured in parallel on a start handshake and compared one bit per cycle, MSB first, using internal shift registers and a bit counter. It produces the same three-flag result (greater / equal / lesser) with fixed latency, a busy indicator and a one-cycle done pulse.

Parameters:
N, 8, operand width in bits; legal range N >= 2.

Ports:
clk  input  1  single system clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset; sampled on the rising edge of clk.
start  input  1  request a compare; accepted only when busy=0.
a  input  N  operand A, unsigned; sampled only on the accepting edge.
b  input  N  operand B, unsigned; sampled only on the accepting edge.
busy  output  1  high while a compare is in progress (RUN state).
done  output  1  one-cycle pulse when a result becomes valid.
a_greater  output  1  registered result, a > b.
a_equal  output  1  registered result, a == b.
a_lesser  output  1  registered result, a < b.

Behaviour:
- FSM states are IDLE, RUN and DONE.
- Reset (rst=1 at an edge, from any state) forces the following:
  - state=IDLE, busy=0, done=0.
  - a_greater=0, a_equal=0, a_lesser=0.
  - bit counter=0, shift registers=0, internal decision flags cleared.
- Reset mid-RUN aborts the compare; no done is produced.
- Accept: start=1 while busy=0 (state IDLE or DONE) at edge k causes the following:
  - shift_a<=a, shift_b<=b, counter<=0, gt/lt decision flags cleared.
  - state<=RUN, busy=1 from the cycle after edge k.
- start while busy=1 is ignored. The operands in flight are unaffected and no request is queued.
- RUN phase: at each of edges k+1 .. k+N, the MSBs of shift_a and shift_b are examined.
  - If no decision has been made yet and the bits differ, set gt when a-bit=1, else set lt.
  - Once gt or lt is set, it is frozen for the rest of the compare; lower bits cannot change it.
  - Both shift registers shift left by 1 and the counter increments.
- No early termination: RUN always lasts exactly N cycles, so latency is data-independent.
- Completion: at edge k+N (counter=N-1) the result is registered, the state moves to DONE, and busy and done are updated.
  - Result inputs include the final bit's comparison.
  - a_greater=gt, a_lesser=lt, a_equal=!(gt|lt).
  - State<=DONE, busy<=0, done<=1.
- Timing: done is high for exactly the one cycle after edge k+N. At edge k+N+1 the block returns to IDLE and done falls, unless start is accepted at that edge.
- Result flags:
  - Change only at completion and hold until the next completion or reset.
  - During RUN they keep the previous result.
  - Exactly one flag is high after any completed compare.
- Back-to-back operation: start=1 in the DONE cycle is accepted. done still falls after one cycle. The next done comes N cycles later, giving a throughput of one compare per N+1 cycles.
- Counter width is $clog2(N). Wrap of the counter is never relied on; the RUN exit is decoded at counter==N-1.
- Simultaneous rst and start: reset wins.

Test Plan:
1. Reset: hold rst=1 for 2 cycles, then release -> busy=0, done=0, all three flags=0; no activity without start.
2. Single compare, N=8: a=8'hA5, b=8'h3C, start pulse at edge k -> busy=1 for 8 cycles; done=1 only in the cycle after edge k+8; a_greater=1, a_equal=0, a_lesser=0.
3. Late-deciding bits and extremes:
   - a=8'h80, b=8'h81 -> a_lesser=1 (decided on LSB).
   - a=8'hFF, b=8'hFF -> a_equal=1.
   - a=8'h00, b=8'hFF -> a_lesser=1.
   - a=8'hFF, b=8'h00 -> a_greater=1.
   - Latency is identical (8 cycles) in every case.
4. Ignored start and operand stability: during RUN of a=8'h10, b=8'h20, pulse start with a=8'hFF, b=8'h00 and change a/b every cycle -> result a_lesser=1, a single done, and no second compare launched.
5. Back-to-back: start in the DONE cycle with a=8'h7F, b=8'h7E -> done pulses 9 cycles apart; the previous flags hold until the second completion, then a_greater=1.
6. Reset mid-operation: assert rst at the 4th RUN cycle -> next cycle busy=0, flags=0, no done. A new start afterward completes normally with 8-cycle latency.
